// File: rtl/ipml_frame_pkg.sv
// ---------------------------------------------------------------------------
// ipml_frame_pkg
// Shared definitions for the IPML frame unpacker:
//   - default header sync marker
//   - FSM state encoding (HUNT = 0, PAYLOAD = 1)
//   - header field positions and field-extraction helpers
// ---------------------------------------------------------------------------
package ipml_frame_pkg;

   localparam logic [15:0] c_SYNC_WORD_DEFAULT = 16'hA5A5;

   // Header layout: [31:16] sync marker, [15:0] payload length in words
   localparam int unsigned c_HDR_WIDTH = 32;
   localparam int unsigned c_SYNC_MSB  = 31;
   localparam int unsigned c_SYNC_LSB  = 16;
   localparam int unsigned c_LEN_MSB   = 15;
   localparam int unsigned c_LEN_LSB   = 0;

   typedef enum logic {
      StHunt    = 1'b0,
      StPayload = 1'b1
   } state_e;

   function automatic logic [15:0] hdr_sync(input logic [c_HDR_WIDTH-1:0] i_word);
      return i_word[c_SYNC_MSB:c_SYNC_LSB];
   endfunction

   function automatic logic [15:0] hdr_len(input logic [c_HDR_WIDTH-1:0] i_word);
      return i_word[c_LEN_MSB:c_LEN_LSB];
   endfunction

endpackage

// File: rtl/ipml_frame_unpacker.sv
// ---------------------------------------------------------------------------
// ipml_frame_unpacker
// Hunts for a header word (sync marker + length) in a word stream read from a
// first-word-fall-through FIFO, then forwards the following <length> payload
// words through a single output register with sop/eop framing.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_data    upstream FIFO read data
//   in_vld     upstream word valid
//   in_rdy     pop request to the upstream FIFO
//   out_data   payload word
//   out_vld    payload word valid
//   out_sop    first payload word of a frame
//   out_eop    last payload word of a frame
//   out_rdy    downstream accepts a word
//   frame_cnt  saturating count of frames fully delivered downstream
//   err_cnt    saturating count of headers rejected for a bad length
//   hunt       high while searching for a header
// ---------------------------------------------------------------------------
module ipml_frame_unpacker
   import ipml_frame_pkg::*;
#(
   parameter int unsigned c_DATA_WIDTH = 32,
   parameter logic [15:0] c_SYNC_WORD  = c_SYNC_WORD_DEFAULT,
   parameter int unsigned c_MAX_LEN    = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [c_DATA_WIDTH-1:0] in_data,
   input  logic                    in_vld,
   output logic                    in_rdy,
   output logic [c_DATA_WIDTH-1:0] out_data,
   output logic                    out_vld,
   output logic                    out_sop,
   output logic                    out_eop,
   input  logic                    out_rdy,
   output logic [15:0]             frame_cnt,
   output logic [15:0]             err_cnt,
   output logic                    hunt
);

   localparam logic [15:0] c_MAX_LEN_W = 16'(c_MAX_LEN);

   state_e                  r_state;
   state_e                  w_state_nxt;
   logic [15:0]             r_remain;
   logic                    r_first;
   logic [c_DATA_WIDTH-1:0] r_out_data;
   logic                    r_out_vld;
   logic                    r_out_sop;
   logic                    r_out_eop;
   logic [15:0]             r_frame_cnt;
   logic [15:0]             r_err_cnt;

   logic [15:0] w_hdr_len;
   logic        w_sync_hit;
   logic        w_len_ok;
   logic        w_in_fire;
   logic        w_out_fire;
   logic        w_hdr_ok;
   logic        w_hdr_bad;
   logic        w_pay_fire;
   logic        w_last;

   assign w_hdr_len  = hdr_len(in_data);
   assign w_sync_hit = (hdr_sync(in_data) == c_SYNC_WORD);
   assign w_len_ok   = (w_hdr_len != 16'd0) && (w_hdr_len <= c_MAX_LEN_W);
   assign w_in_fire  = in_vld & in_rdy;
   assign w_out_fire = r_out_vld & out_rdy;
   assign w_hdr_ok   = (r_state == StHunt) & w_in_fire & w_sync_hit & w_len_ok;
   assign w_hdr_bad  = (r_state == StHunt) & w_in_fire & w_sync_hit & ~w_len_ok;
   assign w_pay_fire = (r_state == StPayload) & w_in_fire;
   assign w_last     = (r_remain == 16'd1);

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StHunt;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StHunt:    if (w_hdr_ok) w_state_nxt = StPayload;
         StPayload: if (w_pay_fire && w_last) w_state_nxt = StHunt;
      endcase
   end

   // FSM: outputs. In PAYLOAD a word is popped only when the output register
   // is free or draining this cycle, which keeps one word per cycle flowing.
   always_comb begin
      in_rdy = 1'b0;
      hunt   = 1'b0;
      unique case (r_state)
         StHunt: begin
            hunt   = 1'b1;
            in_rdy = ~rst;
         end
         StPayload: in_rdy = ~rst & (~r_out_vld | out_rdy);
      endcase
   end

   // Remaining-word counter and first-word flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_remain <= 16'd0;
         r_first  <= 1'b0;
      end else if (w_hdr_ok) begin
         r_remain <= w_hdr_len;
         r_first  <= 1'b1;
      end else if (w_pay_fire) begin
         r_remain <= r_remain - 16'd1;
         r_first  <= 1'b0;
      end
   end

   // Output register stage. A load can only happen when the slot is empty or
   // being emptied, so a stalled word is never overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data <= '0;
         r_out_vld  <= 1'b0;
         r_out_sop  <= 1'b0;
         r_out_eop  <= 1'b0;
      end else if (w_pay_fire) begin
         r_out_data <= in_data;
         r_out_vld  <= 1'b1;
         r_out_sop  <= r_first;
         r_out_eop  <= w_last;
      end else if (w_out_fire) begin
         r_out_vld  <= 1'b0;
         r_out_sop  <= 1'b0;
         r_out_eop  <= 1'b0;
      end
   end

   // Saturating statistics counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= 16'd0;
         r_err_cnt   <= 16'd0;
      end else begin
         if (w_out_fire && r_out_eop && (r_frame_cnt != 16'hFFFF)) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_hdr_bad && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_vld   = r_out_vld;
   assign out_sop   = r_out_sop;
   assign out_eop   = r_out_eop;
   assign frame_cnt = r_frame_cnt;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ipml_frame_unpacker.sv
// ---------------------------------------------------------------------------
// tb_ipml_frame_unpacker
// Self-checking bench: stimulus words are queued together with the payload
// words they should produce; outputs are popped and compared as they transfer.
// ---------------------------------------------------------------------------
module tb_ipml_frame_unpacker;

   typedef struct packed {
      logic [31:0] d;
      logic        sop;
      logic        eop;
   } ow_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = 32'd0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [31:0] out_data;
   logic        out_vld;
   logic        out_sop;
   logic        out_eop;
   logic        out_rdy = 1'b0;
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;
   logic        hunt;

   ipml_frame_unpacker #(
      .c_DATA_WIDTH (32),
      .c_SYNC_WORD  (16'hA5A5),
      .c_MAX_LEN    (1024)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .out_data  (out_data),
      .out_vld   (out_vld),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .out_rdy   (out_rdy),
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt),
      .hunt      (hunt)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] stim_q[$];
   bit          pay_q[$];
   ow_t         exp_q[$];
   int          acc_q[$];
   logic [15:0] exp_frames = 16'd0;
   logic [15:0] exp_errs = 16'd0;

   // Per-cycle observations captured by step()
   bit   o_fire, o_hold, i_fire, s_pay_front;
   ow_t  o_word;
   logic s_in_rdy, s_hunt, s_out_vld;

   task automatic push_frame(input int len, input logic [31:0] base);
      stim_q.push_back({16'hA5A5, 16'(len)});
      pay_q.push_back(1'b0);
      for (int i = 0; i < len; i++) begin
         stim_q.push_back(base + 32'(i));
         pay_q.push_back(1'b1);
         exp_q.push_back({base + 32'(i), (i == 0), (i == len - 1)});
      end
   endtask

   task automatic push_raw(input logic [31:0] w);
      stim_q.push_back(w);
      pay_q.push_back(1'b0);
   endtask

   // Drive one cycle from the stimulus queue; sample on the falling edge.
   task automatic step(input bit rdy);
      out_rdy = rdy;
      in_vld  = (stim_q.size() != 0);
      in_data = in_vld ? stim_q[0] : 32'hDEAD_BEEF;
      @(negedge clk);
      o_fire      = out_vld && out_rdy;
      o_hold      = out_vld && !out_rdy;
      o_word      = {out_data, out_sop, out_eop};
      s_in_rdy    = in_rdy;
      s_hunt      = hunt;
      s_out_vld   = out_vld;
      i_fire      = in_vld && in_rdy;
      s_pay_front = (pay_q.size() != 0) && pay_q[0];
      if (i_fire) begin
         if (pay_q[0]) acc_q.push_back(cyc);
         void'(stim_q.pop_front());
         void'(pay_q.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b0) begin
         errors++; $display("FAIL reset_in_rdy got %b exp 0", in_rdy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (hunt !== 1'b1) begin
         errors++; $display("FAIL reset_hunt got %b exp 1", hunt);
      end
      checks++;
      if ({out_vld, out_sop, out_eop, out_data} !== 35'd0) begin
         errors++;
         $display("FAIL reset_outputs got vld %b sop %b eop %b data %h exp all 0",
                  out_vld, out_sop, out_eop, out_data);
      end
      checks++;
      if ({frame_cnt, err_cnt} !== 32'd0) begin
         errors++; $display("FAIL reset_counters got %h/%h exp 0/0", frame_cnt, err_cnt);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_basic();
      int  n;
      int  a;
      ow_t e;
      acc_q.delete();
      push_frame(3, 32'd1);
      n = 0;
      while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 50) begin
         step(1'b1);
         n++;
         if (o_fire) begin
            checks++;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               errors++; $display("FAIL basic_extra got %h exp none", o_word);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               if (o_word !== e) begin
                  errors++; $display("FAIL basic_word got %h exp %h", o_word, e);
               end
               checks++;
               if (cyc - 1 != a + 1) begin
                  errors++; $display("FAIL basic_latency got %0d exp %0d", cyc - 1, a + 1);
               end
            end
         end
      end
      checks++;
      if (n >= 50) begin
         errors++; $display("FAIL basic_timeout got %0d left exp 0", exp_q.size());
      end
      exp_frames = exp_frames + 16'd1;
      checks++;
      if (frame_cnt !== exp_frames) begin
         errors++; $display("FAIL basic_frame_cnt got %h exp %h", frame_cnt, exp_frames);
      end
   endtask

   task automatic test_bad_headers();
      int n;
      push_raw(32'hA5A5_0000);
      push_raw(32'hA5A5_0401);
      n = 0;
      while (stim_q.size() != 0 && n < 20) begin
         step(1'b1);
         n++;
         checks++;
         if (s_hunt !== 1'b1 || s_out_vld !== 1'b0) begin
            errors++; $display("FAIL bad_hdr_state got hunt %b vld %b exp 1 0", s_hunt, s_out_vld);
         end
      end
      repeat (2) begin
         step(1'b1);
         checks++;
         if (s_hunt !== 1'b1 || s_out_vld !== 1'b0) begin
            errors++; $display("FAIL bad_hdr_after got hunt %b vld %b exp 1 0", s_hunt, s_out_vld);
         end
      end
      exp_errs = exp_errs + 16'd2;
      checks++;
      if (err_cnt !== exp_errs) begin
         errors++; $display("FAIL bad_hdr_err_cnt got %h exp %h", err_cnt, exp_errs);
      end
   endtask

   task automatic test_garbage();
      int  n;
      ow_t e;
      push_raw(32'h1234_5678);
      push_raw(32'h0000_A5A5);
      push_frame(2, 32'hCAFE_0000);
      n = 0;
      while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 50) begin
         step(1'b1);
         n++;
         if (o_fire) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL garbage_extra got %h exp none", o_word);
            end else begin
               e = exp_q.pop_front();
               if (o_word !== e) begin
                  errors++; $display("FAIL garbage_word got %h exp %h", o_word, e);
               end
            end
         end
      end
      checks++;
      if (n >= 50) begin
         errors++; $display("FAIL garbage_timeout got %0d left exp 0", exp_q.size());
      end
      exp_frames = exp_frames + 16'd1;
      checks++;
      if (err_cnt !== exp_errs || frame_cnt !== exp_frames) begin
         errors++;
         $display("FAIL garbage_counters got %h/%h exp %h/%h", err_cnt, frame_cnt,
                  exp_errs, exp_frames);
      end
   endtask

   task automatic test_stall();
      bit  pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int  n;
      int  stalls;
      bit  prev_hold;
      ow_t prev_word;
      ow_t e;
      push_frame(4, 32'h0BAD_0010);
      n = 0;
      stalls = 0;
      prev_hold = 1'b0;
      prev_word = '0;
      while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 50) begin
         step((n < 7) ? pat[n] : 1'b1);
         n++;
         if (prev_hold) begin
            checks++;
            if (s_out_vld !== 1'b1 || o_word !== prev_word) begin
               errors++; $display("FAIL stall_stable got %h exp %h", o_word, prev_word);
            end
         end
         if (o_hold && s_pay_front) begin
            stalls++;
            checks++;
            if (s_in_rdy !== 1'b0) begin
               errors++; $display("FAIL stall_in_rdy got %b exp 0", s_in_rdy);
            end
         end
         if (o_fire) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL stall_extra got %h exp none", o_word);
            end else begin
               e = exp_q.pop_front();
               if (o_word !== e) begin
                  errors++; $display("FAIL stall_word got %h exp %h", o_word, e);
               end
            end
         end
         prev_hold = o_hold;
         prev_word = o_word;
      end
      checks++;
      if (n >= 50 || stalls == 0) begin
         errors++; $display("FAIL stall_progress got n %0d stalls %0d exp n<50 stalls>0", n, stalls);
      end
      exp_frames = exp_frames + 16'd1;
      checks++;
      if (frame_cnt !== exp_frames) begin
         errors++; $display("FAIL stall_frame_cnt got %h exp %h", frame_cnt, exp_frames);
      end
   endtask

   task automatic test_back_to_back();
      int  n;
      int  start;
      int  last;
      ow_t e;
      push_frame(3, 32'h0000_0100);
      push_frame(1, 32'h0000_0200);
      n = 0;
      start = cyc;
      last = -1;
      while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 50) begin
         step(1'b1);
         n++;
         if (o_fire) begin
            last = cyc - 1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_extra got %h exp none", o_word);
            end else begin
               e = exp_q.pop_front();
               if (o_word !== e) begin
                  errors++; $display("FAIL b2b_word got %h exp %h", o_word, e);
               end
            end
         end
      end
      // hdrA, A1..A3, hdrB, B1 accepted on consecutive cycles; B1 out one later
      checks++;
      if (last != start + 6) begin
         errors++; $display("FAIL b2b_throughput got %0d exp %0d", last - start, 6);
      end
      exp_frames = exp_frames + 16'd2;
      checks++;
      if (frame_cnt !== exp_frames) begin
         errors++; $display("FAIL b2b_frame_cnt got %h exp %h", frame_cnt, exp_frames);
      end
   endtask

   task automatic test_saturation();
      int  n;
      ow_t e;
      force dut.r_frame_cnt = 16'hFFFF;
      force dut.r_err_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.r_frame_cnt;
      release dut.r_err_cnt;
      @(posedge clk);
      #1;
      cyc++;
      push_frame(1, 32'h0000_0300);
      push_raw(32'hA5A5_0000);
      push_raw(32'hA5A5_0401);
      push_raw(32'hA5A5_FFFF);
      n = 0;
      while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 50) begin
         step(1'b1);
         n++;
         if (o_fire) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL sat_extra got %h exp none", o_word);
            end else begin
               e = exp_q.pop_front();
               if (o_word !== e) begin
                  errors++; $display("FAIL sat_word got %h exp %h", o_word, e);
               end
            end
         end
      end
      exp_frames = 16'hFFFF;
      exp_errs = 16'hFFFF;
      checks++;
      if (frame_cnt !== exp_frames) begin
         errors++; $display("FAIL sat_frame_cnt got %h exp %h", frame_cnt, exp_frames);
      end
      checks++;
      if (err_cnt !== exp_errs) begin
         errors++; $display("FAIL sat_err_cnt got %h exp %h", err_cnt, exp_errs);
      end
   endtask

   task automatic test_mid_reset();
      int  n;
      int  npay;
      bit  bad_out;
      ow_t e;
      push_frame(5, 32'h0000_0400);
      n = 0;
      npay = 0;
      while (npay < 2 && n < 20) begin
         step(1'b1);
         n++;
         if (i_fire && s_pay_front) npay++;
         if (o_fire) begin
            checks++;
            e = exp_q.pop_front();
            if (o_word !== e) begin
               errors++; $display("FAIL midrst_word got %h exp %h", o_word, e);
            end
         end
      end
      // The remainder of this frame is discarded by the reset
      stim_q.delete(); pay_q.delete(); exp_q.delete(); acc_q.delete();
      rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b0) begin
         errors++; $display("FAIL midrst_in_rdy got %b exp 0", in_rdy);
      end
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
      exp_frames = 16'd0;
      exp_errs = 16'd0;
      @(negedge clk);
      checks++;
      if (out_vld !== 1'b0 || hunt !== 1'b1) begin
         errors++; $display("FAIL midrst_state got vld %b hunt %b exp 0 1", out_vld, hunt);
      end
      checks++;
      if (frame_cnt !== exp_frames || err_cnt !== exp_errs) begin
         errors++; $display("FAIL midrst_counters got %h/%h exp 0/0", frame_cnt, err_cnt);
      end
      @(posedge clk);
      #1;
      cyc++;
      bad_out = 1'b0;
      repeat (8) begin
         step(1'b1);
         if (s_out_vld || o_word.eop) bad_out = 1'b1;
      end
      checks++;
      if (bad_out) begin
         errors++; $display("FAIL midrst_no_eop got output exp none");
      end
      push_frame(2, 32'h0000_0500);
      n = 0;
      while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 50) begin
         step(1'b1);
         n++;
         if (o_fire) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL midrst_extra got %h exp none", o_word);
            end else begin
               e = exp_q.pop_front();
               if (o_word !== e) begin
                  errors++; $display("FAIL midrst_rec_word got %h exp %h", o_word, e);
               end
            end
         end
      end
      exp_frames = exp_frames + 16'd1;
      checks++;
      if (frame_cnt !== exp_frames) begin
         errors++; $display("FAIL midrst_frame_cnt got %h exp %h", frame_cnt, exp_frames);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_headers();
      test_garbage();
      test_stall();
      test_back_to_back();
      test_saturation();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

endmodule
